// File: rtl/router_pkg.sv
// Shared constants and helpers for the router output-steering stage.
// Address encodings follow the packet header bits [1:0].
package router_pkg;

   localparam int NUM_PORTS       = 3;
   localparam int TIMEOUT_DEFAULT = 30;
   localparam int CNT_W_DEFAULT   = 5;

   typedef logic [1:0] addr_t;

   localparam addr_t ADDR_P0      = 2'b00;
   localparam addr_t ADDR_P1      = 2'b01;
   localparam addr_t ADDR_P2      = 2'b10;
   localparam addr_t ADDR_INVALID = 2'b11;

   // One-hot port select; the invalid address selects nothing.
   function automatic logic [NUM_PORTS-1:0] addr_onehot(input addr_t addr);
      logic [NUM_PORTS-1:0] sel;
      sel = '0;
      case (addr)
         ADDR_P0: sel = 3'b001;
         ADDR_P1: sel = 3'b010;
         ADDR_P2: sel = 3'b100;
         default: sel = 3'b000;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/router_sync_timer.sv
// Per-port idle-data supervisor: pulses soft_reset for one cycle after
// TIMEOUT consecutive cycles of valid data that nobody reads.
module router_sync_timer
   import router_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT,
   parameter int CNT_W   = CNT_W_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic vld,
   input  logic rd,
   output logic soft_reset
);

   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_soft_reset;

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt        <= '0;
         r_soft_reset <= 1'b0;
      end else if (!vld || rd) begin
         r_cnt        <= '0;
         r_soft_reset <= 1'b0;
      end else if (r_cnt == LP_LAST) begin
         r_cnt        <= '0;
         r_soft_reset <= 1'b1;
      end else begin
         r_cnt        <= r_cnt + 1'b1;
         r_soft_reset <= 1'b0;
      end
   end

   assign soft_reset = r_soft_reset;

endmodule

// File: rtl/router_sync.sv
// Address capture, write-enable steering and FIFO status supervision
// between the router controller and its three output FIFOs.
module router_sync
   import router_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT,
   parameter int CNT_W   = CNT_W_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       detect_add,
   input  logic [1:0] data_in,
   input  logic       write_enb_reg,
   input  logic       read_enb_0,
   input  logic       read_enb_1,
   input  logic       read_enb_2,
   input  logic       empty_0,
   input  logic       empty_1,
   input  logic       empty_2,
   input  logic       full_0,
   input  logic       full_1,
   input  logic       full_2,
   output logic [2:0] write_enb,
   output logic       fifo_full,
   output logic       vld_out_0,
   output logic       vld_out_1,
   output logic       vld_out_2,
   output logic       soft_reset_0,
   output logic       soft_reset_1,
   output logic       soft_reset_2
);

   addr_t                r_addr;
   logic [NUM_PORTS-1:0] w_sel;
   logic [NUM_PORTS-1:0] w_full;
   logic [NUM_PORTS-1:0] w_vld;
   logic [NUM_PORTS-1:0] w_rd;
   logic [NUM_PORTS-1:0] w_soft_reset;

   // Soft resets clear FIFO contents only; the captured address survives.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_addr <= ADDR_P0;
      end else if (detect_add) begin
         r_addr <= data_in;
      end
   end

   assign w_sel     = addr_onehot(r_addr);
   assign w_full    = {full_2, full_1, full_0};
   assign w_rd      = {read_enb_2, read_enb_1, read_enb_0};
   assign w_vld     = ~{empty_2, empty_1, empty_0};

   assign write_enb = w_sel & {NUM_PORTS{write_enb_reg}};
   assign fifo_full = |(w_sel & w_full);

   assign vld_out_0 = w_vld[0];
   assign vld_out_1 = w_vld[1];
   assign vld_out_2 = w_vld[2];

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_timer
      router_sync_timer #(
         .TIMEOUT (TIMEOUT),
         .CNT_W   (CNT_W)
      ) u_timer (
         .clk        (clk),
         .reset      (reset),
         .vld        (w_vld[g]),
         .rd         (w_rd[g]),
         .soft_reset (w_soft_reset[g])
      );
   end

   assign soft_reset_0 = w_soft_reset[0];
   assign soft_reset_1 = w_soft_reset[1];
   assign soft_reset_2 = w_soft_reset[2];

endmodule

// File: tb/tb_router_sync.sv
// Scoreboard bench for router_sync: the driver predicts each cycle's outputs
// from a streak-count model; a negedge monitor pops and compares.
module tb_router_sync;

   localparam int TIMEOUT = 30;
   localparam int CNT_W   = 5;

   logic       clk;
   logic       reset;
   logic       detect_add;
   logic [1:0] data_in;
   logic       write_enb_reg;
   logic [2:0] rd;
   logic [2:0] empty;
   logic [2:0] full;
   logic [2:0] write_enb;
   logic       fifo_full;
   logic       vld_out_0, vld_out_1, vld_out_2;
   logic       soft_reset_0, soft_reset_1, soft_reset_2;

   typedef struct packed {
      logic [2:0] we;
      logic       ff;
      logic [2:0] vld;
      logic [2:0] sr;
   } exp_t;

   exp_t       exp_q[$];
   int         n_checks = 0;
   int         n_pass   = 0;

   // Reference model: captured address plus, per port, the length of the
   // current run of valid-and-unread cycles.
   logic [1:0] m_addr   = 2'b00;
   int         m_run[3] = '{0, 0, 0};
   logic [2:0] m_sr     = 3'b000;

   router_sync #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .detect_add    (detect_add),
      .data_in       (data_in),
      .write_enb_reg (write_enb_reg),
      .read_enb_0    (rd[0]),
      .read_enb_1    (rd[1]),
      .read_enb_2    (rd[2]),
      .empty_0       (empty[0]),
      .empty_1       (empty[1]),
      .empty_2       (empty[2]),
      .full_0        (full[0]),
      .full_1        (full[1]),
      .full_2        (full[2]),
      .write_enb     (write_enb),
      .fifo_full     (fifo_full),
      .vld_out_0     (vld_out_0),
      .vld_out_1     (vld_out_1),
      .vld_out_2     (vld_out_2),
      .soft_reset_0  (soft_reset_0),
      .soft_reset_1  (soft_reset_1),
      .soft_reset_2  (soft_reset_2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
   endtask

   // Predict this cycle's outputs, then advance the model across one edge.
   task automatic step();
      exp_t e;
      if (!reset) begin
         m_addr = 2'b00;
         m_sr   = 3'b000;
         for (int p = 0; p < 3; p++) m_run[p] = 0;
      end
      e.we  = (m_addr == 2'b11 || !write_enb_reg) ? 3'b000 : (3'b001 << m_addr);
      e.ff  = (m_addr == 2'b11) ? 1'b0 : full[m_addr];
      e.vld = ~empty;
      e.sr  = m_sr;
      exp_q.push_back(e);
      @(posedge clk);
      if (reset) begin
         if (detect_add) m_addr = data_in;
         for (int p = 0; p < 3; p++) begin
            m_run[p] = (!empty[p] && !rd[p]) ? m_run[p] + 1 : 0;
            m_sr[p]  = (m_run[p] > 0) && (m_run[p] % TIMEOUT == 0);
         end
      end
      #1;
   endtask

   task automatic idle_inputs();
      detect_add    = 1'b0;
      data_in       = 2'b00;
      write_enb_reg = 1'b0;
      rd            = 3'b000;
      empty         = 3'b111;
      full          = 3'b000;
   endtask

   // One reset cycle so the following step() is cycle 0 of a test.
   task automatic reset_cycle();
      idle_inputs();
      reset = 1'b0;
      step();
      reset = 1'b1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("write_enb",  {5'd0, write_enb}, {5'd0, e.we});
            check("fifo_full",  {7'd0, fifo_full}, {7'd0, e.ff});
            check("vld_out",    {5'd0, vld_out_2, vld_out_1, vld_out_0}, {5'd0, e.vld});
            check("soft_reset", {5'd0, soft_reset_2, soft_reset_1, soft_reset_0}, {5'd0, e.sr});
         end
      end
   end

   initial begin : driver
      reset = 1'b0;
      idle_inputs();
      @(posedge clk);
      #1;

      // Reset state: addr=0 so a write request steers to FIFO 0.
      write_enb_reg = 1'b1;
      full          = 3'b001;
      step();
      step();

      // Steering to port 2, fifo_full follows full_2.
      reset_cycle();
      detect_add = 1'b1;
      data_in    = 2'b10;
      step();
      detect_add    = 1'b0;
      write_enb_reg = 1'b1;
      full          = 3'b100;
      step();
      full = 3'b011;
      step();

      // Invalid address: no write enable, fifo_full low with all FIFOs full.
      detect_add = 1'b1;
      data_in    = 2'b11;
      step();
      detect_add = 1'b0;
      full       = 3'b111;
      step();
      step();

      // Capture and write in the same cycle use the old address.
      reset_cycle();
      detect_add = 1'b1;
      data_in    = 2'b00;
      step();
      data_in       = 2'b01;
      write_enb_reg = 1'b1;
      step();
      detect_add = 1'b0;
      step();

      // Timeout on port 1 at cycles 30 and 60.
      reset_cycle();
      empty = 3'b101;
      for (int c = 0; c < 62; c++) step();

      // Read in cycle 29 rescues port 0; next pulse in cycle 60.
      reset_cycle();
      empty = 3'b110;
      for (int c = 0; c < 62; c++) begin
         rd[0] = (c == 29);
         step();
      end
      rd = 3'b000;

      // Ports 0 and 2 pulse together; port 1 empties at cycle 12.
      reset_cycle();
      for (int c = 0; c < 34; c++) begin
         empty = (c >= 12) ? 3'b010 : 3'b000;
         step();
      end

      // Reset during a port-0 pulse with port 1 at count 17.
      reset_cycle();
      for (int c = 0; c < 30; c++) begin
         empty = (c >= 13) ? 3'b100 : 3'b110;
         step();
      end
      reset = 1'b0;
      step();
      write_enb_reg = 1'b1;
      step();
      reset         = 1'b1;
      write_enb_reg = 1'b0;
      empty         = 3'b110;
      for (int c = 0; c < 32; c++) step();

      // Randomized traffic with occasional resets.
      reset_cycle();
      for (int c = 0; c < 400; c++) begin
         reset         = ($urandom_range(0, 149) != 0);
         detect_add    = ($urandom_range(0, 9) == 0);
         data_in       = 2'($urandom_range(0, 3));
         write_enb_reg = 1'($urandom_range(0, 1));
         full          = 3'($urandom_range(0, 7));
         for (int p = 0; p < 3; p++) begin
            rd[p] = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 49) == 0) empty[p] = ~empty[p];
         end
         step();
      end
      reset = 1'b1;
      idle_inputs();

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/router_sync.md
# router_sync

Address-steering and output-supervision stage between the router FSM controller and the three output FIFOs. It captures the 2-bit destination address while the controller is in its address-decode state, and routes the controller's single write enable to exactly one FIFO. It returns that FIFO's full flag to the controller and drives one valid_out per port from FIFO empty status. Per-port timeout counters issue a one-cycle soft_reset when a destination leaves valid data unread for TIMEOUT cycles; the controller consumes these soft resets.

## Interface
- TIMEOUT, 30: consecutive unread-valid cycles before a port's soft_reset fires; legal range 2..2^CNT_W.
- CNT_W, 5: timeout counter width.

- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous active-low reset; clears all state immediately, independent of clk.
- detect_add  in  1  controller is in address decode; capture data_in.
- data_in  in  2  destination address (header bits [1:0]).
- write_enb_reg  in  1  controller write request for the current packet byte.
- read_enb_0/1/2  in  1 each  destination read strobe for FIFO n.
- empty_0/1/2  in  1 each  FIFO n empty.
- full_0/1/2  in  1 each  FIFO n full.
- write_enb  out  3  one-hot FIFO write enable; bit n drives FIFO n.
- fifo_full  out  1  full flag of the addressed FIFO, returned to the controller.
- vld_out_0/1/2  out  1 each  FIFO n holds data for its destination.
- soft_reset_0/1/2  out  1 each  one-cycle timeout pulse for port n; goes to both the controller and FIFO n.

## Operation
- **Address register** addr[1:0]:
  - Loaded with data_in on the clk edge where detect_add=1.
  - Held otherwise.
  - Cleared to 2'b00 only by reset; soft resets do not touch it.
- **Write steering** (combinational):
  - write_enb[n] = write_enb_reg & (addr==n).
  - addr=2'b11: write_enb=3'b000 and fifo_full=0.
- **fifo_full** (combinational): full_n for the currently addressed port n.
- **Valid out** (combinational): vld_out_n = ~empty_n.
- **Per-port timer** (one instance per port; register cnt[CNT_W-1:0], registered pulse soft_reset_n):
  - If vld_out_n=0 or read_enb_n=1: cnt <= 0 and soft_reset_n <= 0.
  - Else if cnt==TIMEOUT-1: cnt <= 0 and soft_reset_n <= 1.
  - Else: cnt <= cnt+1 and soft_reset_n <= 0.
- The three timers are fully independent; several soft_reset outputs may pulse in the same cycle.

## Timing
- Reset values:
  - addr=0 and all cnt=0.
  - soft_reset_0/1/2=0.
  - write_enb, fifo_full and vld_out follow their combinational equations from these values and the current inputs.
- **Address capture:** takes effect one cycle after the detect_add edge. If detect_add and write_enb_reg are both high in a cycle, write_enb uses the old addr.
- **Steering latency:** write_enb and fifo_full have zero cycle latency from write_enb_reg, the full inputs and addr.
- **Timeout latency:** with vld_out_n=1 and read_enb_n=0 held from cycle 0, soft_reset_n is high in cycle TIMEOUT only (cycle 30 at default). It returns low in cycle TIMEOUT+1. If the condition persists, the next pulse is in cycle 2·TIMEOUT.
- **Read before timeout:** read_enb_n=1 in any cycle up to and including cycle TIMEOUT-1 suppresses the pulse and restarts the count.
- **Empty before timeout:** empty_n rising mid-count clears cnt on the next edge; no pulse.
- **Reset during a pulse:** reset asserted while soft_reset_n=1 drops it asynchronously.
- **Counter wrap:** cnt never exceeds TIMEOUT-1.

## Structure
- Shared package router_pkg:
  - TIMEOUT default.
  - Address encodings ADDR_P0=2'b00, ADDR_P1=2'b01, ADDR_P2=2'b10, ADDR_INVALID=2'b11.
  - NUM_PORTS=3.
- Sub-module router_sync_timer:
  - Ports: clk, reset, vld, rd, soft_reset.
  - Parameters: TIMEOUT, CNT_W.
  - Instantiated three times.
- Top level holds the address register and the steering/mux logic only.

## Test plan
- **Reset:** assert reset low mid-run with cnt_1=17 and soft_reset_0=1 -> all soft_reset=0 and cnt=0 immediately; addr=0, so write_enb_reg=1 gives write_enb=3'b001.
- **Steering:** detect_add=1, data_in=2'b10, then write_enb_reg=1 next cycle -> write_enb=3'b100 and fifo_full mirrors full_2. Repeat with data_in=2'b11 -> write_enb=3'b000 and fifo_full=0 even with all full_n=1.
- **Timeout:** empty_1=0 and read_enb_1=0 held from cycle 0 -> soft_reset_1 high in cycle 30 only, again in cycle 60; soft_reset_0 and soft_reset_2 stay 0.
- **Rescue by read:** empty_0=0; read_enb_0=1 pulse in cycle 29 -> no pulse at 30; next pulse in cycle 60.
- **Concurrency and empty:**
  - Ports 0 and 2 both valid/unread from cycle 0 -> both pulse in cycle 30.
  - empty_1 rises in cycle 12 -> port 1 never pulses.
- **Simultaneous capture and write:** addr=0, then detect_add=1 (data_in=1) and write_enb_reg=1 in the same cycle -> write_enb=3'b001 that cycle and 3'b010 on the next write.
